// File: rtl/p_scatter.sv
// Sequential deserializer: accepts one word per handshake and spreads the words
// in order across NB_OUTS registered slots, then offers the full frame downstream.
module p_scatter #(
  parameter int BUS_WIDTH = 1,
  parameter int NB_OUTS   = 2,
  parameter int IDX_W     = (NB_OUTS > 1 ? $clog2(NB_OUTS) : 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [BUS_WIDTH-1:0] in_bus,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out_buses [NB_OUTS-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     fill_idx
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_OUTS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             slot_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_idx  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_idx  <= idx_nxt;
      in_ready  <= (state_nxt == FILL);
      out_valid <= (state_nxt == HOLD);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = fill_idx;
    slot_we   = 1'b0;
    case (state)
      FILL: begin
        if (in_valid && in_ready) begin
          slot_we = 1'b1;
          if (fill_idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            idx_nxt = fill_idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    // clear drops any word or frame handed over in the same cycle
    if (clear) begin
      state_nxt = FILL;
      idx_nxt   = '0;
      slot_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB_OUTS; i++) out_buses[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_OUTS; i++) begin
        if (slot_we && fill_idx == IDX_W'(i)) out_buses[i] <= in_bus;
      end
    end
  end

endmodule

// File: tb/tb_p_scatter.sv
// Scoreboard bench for p_scatter: a 4x8-bit instance and a 1x4-bit instance.
module tb_p_scatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: BUS_WIDTH=8, NB_OUTS=4
  logic       a_rst_n, a_clear, a_in_valid, a_out_ready;
  logic [7:0] a_in_bus;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out [3:0];
  logic [1:0] a_fill_idx;

  // instance B: BUS_WIDTH=4, NB_OUTS=1
  logic       b_rst_n, b_clear, b_in_valid, b_out_ready;
  logic [3:0] b_in_bus;
  logic       b_in_ready, b_out_valid;
  logic [3:0] b_out [0:0];
  logic [0:0] b_fill_idx;

  p_scatter #(.BUS_WIDTH(8), .NB_OUTS(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .clear(a_clear), .in_bus(a_in_bus),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_buses(a_out),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .fill_idx(a_fill_idx)
  );

  p_scatter #(.BUS_WIDTH(4), .NB_OUTS(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clear(b_clear), .in_bus(b_in_bus),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_buses(b_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .fill_idx(b_fill_idx)
  );

  logic [31:0] a_exp_q [$];
  logic [3:0]  b_exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] a_frame();
    return {a_out[3], a_out[2], a_out[1], a_out[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitors: compare each frame actually handed off against the scoreboard
  always @(negedge clk) begin
    if (a_rst_n && !a_clear && a_out_valid && a_out_ready) begin
      if (a_exp_q.size() == 0) chk("a_unexpected_frame", a_frame(), 32'hxxxx_xxxx);
      else chk("a_frame", a_frame(), a_exp_q.pop_front());
    end
    if (b_rst_n && !b_clear && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) chk("b_unexpected_frame", {28'd0, b_out[0]}, 32'hxxxx_xxxx);
      else chk("b_frame", {28'd0, b_out[0]}, {28'd0, b_exp_q.pop_front()});
    end
  end

  task automatic a_send(input logic [7:0] w);
    a_in_valid = 1'b1;
    a_in_bus   = w;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_handoff();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("a_ov_after_handoff", {31'd0, a_out_valid}, 32'd0);
    chk("a_ir_after_handoff", {31'd0, a_in_ready}, 32'd1);
    chk("a_idx_after_handoff", {30'd0, a_fill_idx}, 32'd0);
  endtask

  initial begin
    a_rst_n = 1'b0; a_clear = 1'b0; a_in_valid = 1'b1; a_in_bus = 8'h5A; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_clear = 1'b0; b_in_valid = 1'b0; b_in_bus = 4'h0; b_out_ready = 1'b0;

    // reset with in_valid held high
    step(); step();
    chk("a_rst_slots", a_frame(), 32'h0);
    chk("a_rst_ov", {31'd0, a_out_valid}, 32'd0);
    chk("a_rst_ir", {31'd0, a_in_ready}, 32'd1);
    chk("a_rst_idx", {30'd0, a_fill_idx}, 32'd0);
    a_rst_n = 1'b1; a_in_valid = 1'b0;
    step();

    // basic frame, then hold against back-pressure
    a_send(8'h11); a_send(8'h22); a_send(8'h33);
    chk("a_idx_3", {30'd0, a_fill_idx}, 32'd3);
    chk("a_ov_before_last", {31'd0, a_out_valid}, 32'd0);
    a_send(8'h44);
    chk("a_ov_rise", {31'd0, a_out_valid}, 32'd1);
    chk("a_ir_hold", {31'd0, a_in_ready}, 32'd0);
    chk("a_basic_slots", a_frame(), 32'h4433_2211);
    a_exp_q.push_back(32'h4433_2211);
    a_in_valid = 1'b1; a_in_bus = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_hold_slots", a_frame(), 32'h4433_2211);
      chk("a_hold_ov", {31'd0, a_out_valid}, 32'd1);
    end
    a_in_valid = 1'b0;
    a_handoff();

    // frame with idle gaps between words
    for (int i = 0; i < 4; i++) begin
      a_send(8'hA0 + 8'(i));
      step();
    end
    chk("a_gap_ov", {31'd0, a_out_valid}, 32'd1);
    chk("a_gap_slots", a_frame(), 32'hA3A2_A1A0);
    a_exp_q.push_back(32'hA3A2_A1A0);
    a_handoff();

    // clear together with an accept: word dropped, old slots untouched
    a_send(8'h01); a_send(8'h02);
    chk("a_idx_2", {30'd0, a_fill_idx}, 32'd2);
    a_clear = 1'b1;
    a_send(8'h03);
    a_clear = 1'b0;
    chk("a_clr_idx", {30'd0, a_fill_idx}, 32'd0);
    chk("a_clr_ov", {31'd0, a_out_valid}, 32'd0);
    chk("a_clr_slots", a_frame(), 32'hA3A2_0201);
    a_send(8'h05); a_send(8'h06); a_send(8'h07); a_send(8'h08);
    chk("a_post_clr_slots", a_frame(), 32'h0807_0605);
    a_exp_q.push_back(32'h0807_0605);
    a_handoff();

    // reset during HOLD
    a_send(8'hC0); a_send(8'hC1); a_send(8'hC2); a_send(8'hC3);
    chk("a_pre_rst_ov", {31'd0, a_out_valid}, 32'd1);
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1;
    chk("a_rsth_ov", {31'd0, a_out_valid}, 32'd0);
    chk("a_rsth_idx", {30'd0, a_fill_idx}, 32'd0);
    chk("a_rsth_slots", a_frame(), 32'h0);

    // reset during FILL
    a_send(8'hD0); a_send(8'hD1);
    chk("a_pre_rstf_idx", {30'd0, a_fill_idx}, 32'd2);
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1;
    chk("a_rstf_ov", {31'd0, a_out_valid}, 32'd0);
    chk("a_rstf_idx", {30'd0, a_fill_idx}, 32'd0);
    chk("a_rstf_slots", a_frame(), 32'h0);

    // single-slot instance
    b_rst_n = 1'b1;
    step();
    chk("b_rst_ir", {31'd0, b_in_ready}, 32'd1);
    chk("b_rst_ov", {31'd0, b_out_valid}, 32'd0);
    b_in_valid = 1'b1; b_in_bus = 4'h9;
    step();
    b_in_valid = 1'b0;
    chk("b_ov_rise", {31'd0, b_out_valid}, 32'd1);
    chk("b_slot_9", {28'd0, b_out[0]}, 32'h9);
    chk("b_idx", {31'd0, b_fill_idx}, 32'd0);
    b_exp_q.push_back(4'h9);
    b_in_valid = 1'b1; b_in_bus = 4'h3; b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("b_ov_after_handoff", {31'd0, b_out_valid}, 32'd0);
    chk("b_ir_after_handoff", {31'd0, b_in_ready}, 32'd1);
    chk("b_no_accept_on_handoff", {28'd0, b_out[0]}, 32'h9);
    step();
    b_in_valid = 1'b0;
    chk("b_ov_second", {31'd0, b_out_valid}, 32'd1);
    chk("b_slot_3", {28'd0, b_out[0]}, 32'h3);
    chk("b_idx_second", {31'd0, b_fill_idx}, 32'd0);
    b_exp_q.push_back(4'h3);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    step();

    chk("a_queue_drained", a_exp_q.size(), 32'd0);
    chk("b_queue_drained", b_exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_scatter.md
Name: p_scatter

Overview:
Parametrized sequential deserializer. It accepts one BUS_WIDTH word per handshake on a single input bus and distributes the words in order into NB_OUTS registered output slots. When every slot is filled, it presents the whole frame on a valid/ready output handshake. It is the one-to-many counterpart of the many-bus reduction blocks in the boolean/bus library, and feeds multi-bus consumers such as parametrized AND/OR reducers from a narrow source.

Parameters:
BUS_WIDTH, 1, width in bits of the input word and of each output slot.
NB_OUTS, 2, number of output slots per frame; must be >= 1.
IDX_W, (NB_OUTS > 1 ? $clog2(NB_OUTS) : 1), width of the slot index; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
clear  input  1  synchronous abort of the current frame; lower priority than rst_n.
in_bus  input  BUS_WIDTH  incoming word.
in_valid  input  1  in_bus carries a word.
in_ready  output  1  block accepts a word this cycle.
out_buses  output  BUS_WIDTH x [NB_OUTS-1:0] (unpacked array)  assembled frame; slot 0 holds the first word accepted.
out_valid  output  1  out_buses holds a complete frame.
out_ready  input  1  consumer takes the frame this cycle.
fill_idx  output  IDX_W  index of the next slot to be written (debug/status).

Behaviour:
- Register every output; no combinational path from in_valid or out_ready to any output.
- State machine has two states:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (rst_n=0 at a clock edge): state=FILL, fill_idx=0, all out_buses slots=0, out_valid=0, in_ready=1. Reset takes effect regardless of clear, in_valid or out_ready.
- FILL, accept when in_valid && in_ready:
  - out_buses[fill_idx] <= in_bus.
  - If fill_idx == NB_OUTS-1: fill_idx <= 0 and state <= HOLD, so out_valid rises on the next cycle.
  - Otherwise fill_idx <= fill_idx+1.
- FILL with in_valid=0: no change.
- Latency: out_valid asserts 1 cycle after the NB_OUTS-th accepted word. Frame throughput is at most one frame per NB_OUTS+1 cycles.
- HOLD:
  - out_buses is stable and in_ready=0; in_valid is ignored and no word is consumed.
  - On out_valid && out_ready: state <= FILL and in_ready=1 on the next cycle.
  - A word is never accepted in the same cycle as a frame handoff.
- out_ready while in FILL is ignored.
- clear=1 (rst_n=1), from any state: state <= FILL, fill_idx <= 0, out_valid <= 0.
  - Slot contents are not zeroed.
  - clear overrides a simultaneous accept: the word is dropped, no slot is written, fill_idx is 0.
  - clear overrides a simultaneous frame handoff: the frame counts as discarded.
- Slots not yet written in the current frame keep their previous values. out_buses is only meaningful while out_valid=1.
- NB_OUTS=1:
  - Each accepted word moves straight to HOLD.
  - fill_idx stays 0.
  - IDX_W=1.
- No arithmetic beyond the fill_idx increment. fill_idx never exceeds NB_OUTS-1; there is no wrap past the last slot except through the HOLD transition.

Test Plan:
- Reset: BUS_WIDTH=8, NB_OUTS=4; hold rst_n=0 for 2 cycles with in_valid=1 -> all slots 0x00, out_valid=0, in_ready=1, fill_idx=0; no slot written.
- Basic frame: words 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_ready=0 -> out_valid=1 on the cycle after 0x44; out_buses[0..3]=0x11,0x22,0x33,0x44; in_ready=0; held unchanged for 5 cycles while in_valid=1 with 0xFF.
- Handoff and back-pressure: from the previous HOLD, pulse out_ready for 1 cycle -> next cycle out_valid=0, in_ready=1, fill_idx=0. Next frame 0xA0..0xA3, sent with in_valid gaps every other cycle -> frame completes after 4 accepts; slots=0xA0..0xA3.
- Clear mid-frame: accept 0x01,0x02, then clear=1 together with in_valid=1 carrying 0x03 -> fill_idx=0, 0x03 not stored. Then 0x05..0x08 -> frame 0x05,0x06,0x07,0x08.
- Reset mid-HOLD and mid-FILL: assert rst_n=0 while out_valid=1 and again after 2 accepts -> in both cases out_valid=0, fill_idx=0, slots all 0 next cycle.
- NB_OUTS=1, BUS_WIDTH=4: accept 0x9 -> out_valid=1 next cycle, out_buses[0]=0x9. Assert out_ready and in_valid (0x3) in the same cycle -> 0x3 is not accepted until in_ready returns 1.
